gcd_datapath: RTL and testbench



---
 rtl/gcd_pkg.sv | 24 ++
 rtl/gcd_compare.sv | 29 ++
 rtl/gcd_datapath.sv | 167 ++++++++++++++++
 tb/tb_gcd_datapath.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD controller and datapath.
// Holds the controller command codes, the status codes returned to the
// controller, and the datapath state encoding.
package gcd_pkg;

  // Controller command codes
  localparam logic [1:0] CTRL_NOP    = 2'd0;
  localparam logic [1:0] CTRL_SUB_A  = 2'd1;
  localparam logic [1:0] CTRL_SUB_B  = 2'd2;
  localparam logic [1:0] CTRL_FINISH = 2'd3;

  // Status codes returned to the controller
  localparam logic [1:0] ST_DONE = 2'd0;
  localparam logic [1:0] ST_AGT  = 2'd1;
  localparam logic [1:0] ST_ALT  = 2'd2;

  // Datapath state
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } gcd_state_t;

endpackage

// File: rtl/gcd_compare.sv
// Zero detect and magnitude compare of the two operand registers,
// producing the 2-bit status code for the controller.
// A zero operand reports DONE ahead of any compare so that a pair like
// (x,0) can never be asked to subtract forever.
module gcd_compare
  import gcd_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [1:0]        o_status
);

  // Zero check first, then ordering; equal operands are also DONE
  always_comb begin
    o_status = ST_DONE;
    if ((i_a == '0) || (i_b == '0)) begin
      o_status = ST_DONE;
    end else if (i_a > i_b) begin
      o_status = ST_AGT;
    end else if (i_a < i_b) begin
      o_status = ST_ALT;
    end else begin
      o_status = ST_DONE;
    end
  end

endmodule

// File: rtl/gcd_datapath.sv
// GCD datapath: operand registers A/B, subtract-until-equal execution of
// the controller's command code, load and result valid/ready handshakes,
// and a sticky protocol error flag.
// Optional build macro GCD_ITER_LIMIT_EN adds an iteration counter that
// aborts a computation after MAX_ITER executed subtractions (err=1,
// result=0). Without the macro there is no counter and no limit.
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int MAX_ITER = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic [1:0]        ctrl,
  output logic [1:0]        status,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              err
);

  gcd_state_t        r_state;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_result;
  logic              r_result_valid;
  logic              r_err;
  logic              r_load_ready;

  logic [1:0]        w_status;
  logic              w_load_fire;
  logic              w_in_run;
  logic              w_limit_hit;
  logic              w_sub_a;
  logic              w_sub_b;
  logic [DATA_W-1:0] w_a_minus_b;
  logic [DATA_W-1:0] w_b_minus_a;

  gcd_compare #(
    .DATA_W (DATA_W)
  ) u_compare (
    .i_a      (r_a),
    .i_b      (r_b),
    .o_status (w_status)
  );

  // Subtractions are only ever committed when status says the minuend is
  // strictly larger, so these differences never wrap.
  assign w_a_minus_b = r_a - r_b;
  assign w_b_minus_a = r_b - r_a;

  assign w_load_fire = (r_state == S_IDLE) && load_valid && r_load_ready;
  assign w_in_run    = (r_state == S_RUN);
  assign w_sub_a     = w_in_run && !w_limit_hit && (ctrl == CTRL_SUB_A) && (w_status == ST_AGT);
  assign w_sub_b     = w_in_run && !w_limit_hit && (ctrl == CTRL_SUB_B) && (w_status == ST_ALT);

`ifdef GCD_ITER_LIMIT_EN
  localparam int                ITER_W   = $clog2(MAX_ITER + 1);
  localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

  logic [ITER_W-1:0] r_iter;

  assign w_limit_hit = (r_iter == ITER_MAX);

  // Count executed subtractions; a new load starts the count over
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_iter <= '0;
    end else if (w_load_fire) begin
      r_iter <= '0;
    end else if (w_sub_a || w_sub_b) begin
      r_iter <= r_iter + 1'b1;
    end
  end
`else
  logic w_unused_iter_cfg;

  assign w_limit_hit       = 1'b0;
  assign w_unused_iter_cfg = (MAX_ITER > 0);
`endif

  // Control FSM with operand, result and error registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_a            <= '0;
      r_b            <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_err          <= 1'b0;
      r_load_ready   <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_load_fire) begin
            r_a          <= a_in;
            r_b          <= b_in;
            r_err        <= 1'b0;
            r_load_ready <= 1'b0;
            r_state      <= S_RUN;
          end
        end

        S_RUN: begin
          if (w_limit_hit) begin
            r_err          <= 1'b1;
            r_result       <= '0;
            r_result_valid <= 1'b1;
            r_state        <= S_HOLD;
          end else begin
            case (ctrl)
              CTRL_SUB_A: begin
                if (w_sub_a) begin
                  r_a <= w_a_minus_b;
                end else begin
                  r_err <= 1'b1;
                end
              end
              CTRL_SUB_B: begin
                if (w_sub_b) begin
                  r_b <= w_b_minus_a;
                end else begin
                  r_err <= 1'b1;
                end
              end
              CTRL_FINISH: begin
                if (w_status == ST_DONE) begin
                  r_result       <= (r_a == '0) ? r_b : r_a;
                  r_result_valid <= 1'b1;
                  r_state        <= S_HOLD;
                end else begin
                  r_err <= 1'b1;
                end
              end
              default: begin
              end
            endcase
          end
        end

        S_HOLD: begin
          if (result_ready) begin
            r_result_valid <= 1'b0;
            r_load_ready   <= 1'b1;
            r_state        <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign load_ready   = r_load_ready;
  assign status       = w_status;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign err          = r_err;

endmodule

// File: tb/tb_gcd_datapath.sv
// Self-checking bench for gcd_datapath. Expected GCDs are pushed to a
// scoreboard queue at load time and popped when the result is presented.
// With GCD_ITER_LIMIT_EN defined the DUT is built with MAX_ITER=4 and the
// iteration-limit scenario runs instead of the long computations.
module tb_gcd_datapath;
  import gcd_pkg::*;

`ifdef GCD_ITER_LIMIT_EN
  localparam int TB_MAX_ITER = 4;
`else
  localparam int TB_MAX_ITER = 255;
`endif

  logic       clk;
  logic       reset;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic [1:0] ctrl;
  logic [1:0] status;
  logic [7:0] result;
  logic       result_valid;
  logic       result_ready;
  logic       err;

  int         n_checks;
  int         n_errors;
  logic [7:0] exp_q[$];

  gcd_datapath #(
    .DATA_W   (8),
    .MAX_ITER (TB_MAX_ITER)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .a_in         (a_in),
    .b_in         (b_in),
    .ctrl         (ctrl),
    .status       (status),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Euclid by remainder, independent of the subtractive hardware
  function automatic logic [7:0] gcd_model(input logic [7:0] a, input logic [7:0] b);
    int x;
    int y;
    int t;
    x = a;
    y = b;
    if (x == 0) return b;
    if (y == 0) return a;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x[7:0];
  endfunction

  task automatic do_load(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp_res);
    int k;
    k = 0;
    while (!load_ready && k < 20) begin
      tick();
      k++;
    end
    if (!load_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL load_wait: load_ready=%0b required 1", load_ready);
    end
    a_in       = a;
    b_in       = b;
    load_valid = 1'b1;
    exp_q.push_back(exp_res);
    tick();
    load_valid = 1'b0;
  endtask

  // Drive commands as status dictates until FINISH has been issued
  task automatic run_to_finish(output int subs);
    logic [1:0] c;
    bit         done;
    subs = 0;
    done = 1'b0;
    for (int k = 0; k < 600 && !done; k++) begin
      case (status)
        ST_AGT:  c = CTRL_SUB_A;
        ST_ALT:  c = CTRL_SUB_B;
        default: c = CTRL_FINISH;
      endcase
      ctrl = c;
      tick();
      if (c == CTRL_FINISH) done = 1'b1;
      else subs++;
    end
    ctrl = CTRL_NOP;
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL run_timeout: status=%0d never reached done", status);
    end
  endtask

  task automatic release_result();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  function automatic logic [7:0] pop_exp();
    if (exp_q.size() == 0) return 8'hxx;
    return exp_q.pop_front();
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    tick();
    n_checks++; if (load_ready !== 1'b1)   begin n_errors++; $display("FAIL rst_load_ready: got %0b want 1", load_ready); end
    n_checks++; if (result_valid !== 1'b0) begin n_errors++; $display("FAIL rst_result_valid: got %0b want 0", result_valid); end
    n_checks++; if (err !== 1'b0)          begin n_errors++; $display("FAIL rst_err: got %0b want 0", err); end
    n_checks++; if (result !== 8'd0)       begin n_errors++; $display("FAIL rst_result: got %0d want 0", result); end
    n_checks++; if (status !== ST_DONE)    begin n_errors++; $display("FAIL rst_status: got %0d want 0", status); end
    reset = 1'b1;
    tick();
    n_checks++; if (load_ready !== 1'b1)   begin n_errors++; $display("FAIL post_rst_load_ready: got %0b want 1", load_ready); end
  endtask

  task automatic test_sequence();
    logic [7:0] seq_a [5];
    logic [7:0] seq_b [5];
    logic [1:0] seq_st[5];
    logic [7:0] e;
    seq_a  = '{8'd48, 8'd30, 8'd12, 8'd12, 8'd6};
    seq_b  = '{8'd18, 8'd18, 8'd18, 8'd6,  8'd6};
    seq_st = '{ST_AGT, ST_AGT, ST_ALT, ST_AGT, ST_DONE};
    do_load(8'd48, 8'd18, gcd_model(8'd48, 8'd18));
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (dut.r_a !== seq_a[i] || dut.r_b !== seq_b[i]) begin
        n_errors++;
        $display("FAIL seq_regs[%0d]: got (%0d,%0d) want (%0d,%0d)", i, dut.r_a, dut.r_b, seq_a[i], seq_b[i]);
      end
      n_checks++;
      if (status !== seq_st[i]) begin
        n_errors++;
        $display("FAIL seq_status[%0d]: got %0d want %0d", i, status, seq_st[i]);
      end
      if (i < 4) begin
        ctrl = (seq_st[i] == ST_AGT) ? CTRL_SUB_A : CTRL_SUB_B;
        tick();
      end
    end
    ctrl = CTRL_FINISH;
    tick();
    ctrl = CTRL_NOP;
    e = pop_exp();
    n_checks++; if (result_valid !== 1'b1) begin n_errors++; $display("FAIL seq_valid: got %0b want 1", result_valid); end
    n_checks++; if (result !== e)          begin n_errors++; $display("FAIL seq_result: got %0d want %0d", result, e); end
    n_checks++; if (err !== 1'b0)          begin n_errors++; $display("FAIL seq_err: got %0b want 0", err); end
    release_result();
    n_checks++; if (result_valid !== 1'b0) begin n_errors++; $display("FAIL seq_release_valid: got %0b want 0", result_valid); end
    n_checks++; if (load_ready !== 1'b1)   begin n_errors++; $display("FAIL seq_release_ready: got %0b want 1", load_ready); end
  endtask

  task automatic test_zero_equal();
    logic [7:0] pa[4];
    logic [7:0] pb[4];
    logic [7:0] e;
    int         subs;
    pa = '{8'd0, 8'd13, 8'd0, 8'd9};
    pb = '{8'd7, 8'd13, 8'd0, 8'd0};
    for (int i = 0; i < 4; i++) begin
      do_load(pa[i], pb[i], gcd_model(pa[i], pb[i]));
      n_checks++;
      if (status !== ST_DONE) begin
        n_errors++;
        $display("FAIL zeq_status[%0d]: got %0d want 0", i, status);
      end
      run_to_finish(subs);
      e = pop_exp();
      n_checks++;
      if (result_valid !== 1'b1 || result !== e) begin
        n_errors++;
        $display("FAIL zeq_result[%0d]: got valid=%0b res=%0d want valid=1 res=%0d", i, result_valid, result, e);
      end
      release_result();
    end
  endtask

  task automatic test_hold();
    logic [7:0] e;
    int         subs;
    do_load(8'd20, 8'd8, gcd_model(8'd20, 8'd8));
    run_to_finish(subs);
    e = pop_exp();
    for (int i = 0; i < 5; i++) begin
      result_ready = 1'b0;
      ctrl         = CTRL_SUB_A;
      tick();
      n_checks++;
      if (result !== e || result_valid !== 1'b1 || load_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL hold[%0d]: got res=%0d valid=%0b lready=%0b want res=%0d valid=1 lready=0",
                 i, result, result_valid, load_ready, e);
      end
    end
    ctrl = CTRL_NOP;
    release_result();
    n_checks++; if (result_valid !== 1'b0) begin n_errors++; $display("FAIL hold_release_valid: got %0b want 0", result_valid); end
    n_checks++; if (load_ready !== 1'b1)   begin n_errors++; $display("FAIL hold_release_ready: got %0b want 1", load_ready); end
  endtask

  task automatic test_illegal();
    logic [7:0] e;
    int         subs;
    do_load(8'd5, 8'd9, gcd_model(8'd5, 8'd9));
    ctrl = CTRL_SUB_A;
    tick();
    ctrl = CTRL_NOP;
    n_checks++;
    if (dut.r_a !== 8'd5 || dut.r_b !== 8'd9) begin
      n_errors++;
      $display("FAIL illegal_regs: got (%0d,%0d) want (5,9)", dut.r_a, dut.r_b);
    end
    n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL illegal_err: got %0b want 1", err); end
    ctrl = CTRL_FINISH;
    tick();
    ctrl = CTRL_NOP;
    n_checks++;
    if (result_valid !== 1'b0 || load_ready !== 1'b0 || err !== 1'b1) begin
      n_errors++;
      $display("FAIL early_finish: got valid=%0b lready=%0b err=%0b want 0 0 1", result_valid, load_ready, err);
    end
    run_to_finish(subs);
    e = pop_exp();
    n_checks++; if (result !== e)  begin n_errors++; $display("FAIL illegal_result: got %0d want %0d", result, e); end
    n_checks++; if (err !== 1'b1)  begin n_errors++; $display("FAIL err_sticky: got %0b want 1", err); end
    release_result();
    do_load(8'd6, 8'd4, gcd_model(8'd6, 8'd4));
    n_checks++; if (err !== 1'b0)  begin n_errors++; $display("FAIL err_clear_on_load: got %0b want 0", err); end
    run_to_finish(subs);
    e = pop_exp();
    n_checks++; if (result !== e)  begin n_errors++; $display("FAIL after_clear_result: got %0d want %0d", result, e); end
    release_result();
  endtask

  task automatic test_reset_midrun();
    logic [7:0] e;
    int         subs;
    do_load(8'd100, 8'd30, gcd_model(8'd100, 8'd30));
    ctrl = CTRL_SUB_B;
    tick();
    ctrl = CTRL_SUB_A;
    tick();
    tick();
    ctrl = CTRL_NOP;
    n_checks++;
    if (dut.r_a !== 8'd40 || err !== 1'b1) begin
      n_errors++;
      $display("FAIL midrun_pre: got a=%0d err=%0b want a=40 err=1", dut.r_a, err);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (load_ready !== 1'b1 || result_valid !== 1'b0 || err !== 1'b0 || result !== 8'd0 || status !== ST_DONE) begin
      n_errors++;
      $display("FAIL async_reset: got lready=%0b valid=%0b err=%0b res=%0d st=%0d want 1 0 0 0 0",
               load_ready, result_valid, err, result, status);
    end
    void'(exp_q.pop_back());
    reset = 1'b1;
    tick();
    do_load(8'd21, 8'd14, gcd_model(8'd21, 8'd14));
    run_to_finish(subs);
    e = pop_exp();
    n_checks++;
    if (result_valid !== 1'b1 || result !== e) begin
      n_errors++;
      $display("FAIL post_reset_result: got valid=%0b res=%0d want 1 %0d", result_valid, result, e);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] e;
    int         subs;
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom_range(1, 255));
      b = 8'($urandom_range(1, 255));
      do_load(a, b, gcd_model(a, b));
      run_to_finish(subs);
      e = pop_exp();
      n_checks++;
      if (result_valid !== 1'b1 || result !== e || err !== 1'b0) begin
        n_errors++;
        $display("FAIL b2b[%0d] gcd(%0d,%0d): got valid=%0b res=%0d err=%0b want 1 %0d 0",
                 i, a, b, result_valid, result, err, e);
      end
      release_result();
    end
  endtask

`ifdef GCD_ITER_LIMIT_EN
  task automatic test_iter_limit();
    logic [7:0] e;
    do_load(8'd255, 8'd1, 8'd0);
    for (int i = 0; i < 4; i++) begin
      ctrl = CTRL_SUB_A;
      tick();
    end
    n_checks++;
    if (dut.r_a !== 8'd251 || err !== 1'b0 || result_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL limit_pre: got a=%0d err=%0b valid=%0b want 251 0 0", dut.r_a, err, result_valid);
    end
    tick();
    ctrl = CTRL_NOP;
    e = pop_exp();
    n_checks++;
    if (err !== 1'b1 || result !== e || result_valid !== 1'b1 || dut.r_a !== 8'd251) begin
      n_errors++;
      $display("FAIL limit_hit: got err=%0b res=%0d valid=%0b a=%0d want 1 %0d 1 251",
               err, result, result_valid, dut.r_a, e);
    end
    release_result();
  endtask
`endif

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    reset        = 1'b0;
    load_valid   = 1'b0;
    a_in         = 8'd0;
    b_in         = 8'd0;
    ctrl         = CTRL_NOP;
    result_ready = 1'b0;
    test_reset();
`ifdef GCD_ITER_LIMIT_EN
    test_zero_equal();
    test_iter_limit();
`else
    test_sequence();
    test_zero_equal();
    test_hold();
    test_illegal();
    test_reset_midrun();
    test_back_to_back();
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
